// File: rtl/regfile_ctrl.sv
// Controller for a 32 x 32-bit register file stored in an external dual-port RAM.
// After reset it zeroes the RAM two words per cycle, then serves writes and paired reads.
module regfile_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_rdy,
    input  logic        rd_req,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic [4:0]  ram_addra,
    output logic [4:0]  ram_addrb,
    output logic        ram_cea,
    output logic        ram_ceb,
    output logic        ram_wea,
    output logic        ram_web,
    output logic [31:0] ram_dia,
    output logic [31:0] ram_dib,
    input  logic [31:0] ram_doa,
    input  logic [31:0] ram_dob,
    output logic        ram_rsta,
    output logic        ram_rstb
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, zero1_q, zero2_q;
    logic [31:0] data1_q, data2_q;
    logic        writeHit;
    logic [31:0] readData1, readData2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CLEAR;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                state_d = RUN;
            end
        end
    end

    // Writes to x0 never touch the RAM, so they must not steal port A from a read.
    assign writeHit = wr_en && (wr_addr != 5'd0);

    always_comb begin
        wr_rdy    = (state_q == RUN);
        rd_gnt    = 1'b0;
        ram_addra = 5'd0;
        ram_addrb = 5'd0;
        ram_cea   = 1'b0;
        ram_ceb   = 1'b0;
        ram_wea   = 1'b0;
        ram_web   = 1'b0;
        ram_dia   = 32'd0;
        ram_dib   = 32'd0;
        if (state_q == CLEAR) begin
            ram_addra = {cnt_q, 1'b0};
            ram_addrb = {cnt_q, 1'b1};
            ram_cea   = 1'b1;
            ram_ceb   = 1'b1;
            ram_wea   = 1'b1;
            ram_web   = 1'b1;
        end else if (writeHit) begin
            ram_addra = wr_addr;
            ram_cea   = 1'b1;
            ram_wea   = 1'b1;
            ram_dia   = wr_data;
        end else if (rd_req) begin
            rd_gnt    = 1'b1;
            ram_addra = rd_addr1;
            ram_addrb = rd_addr2;
            ram_cea   = 1'b1;
            ram_ceb   = 1'b1;
        end
    end

    assign ram_rsta = 1'b0;
    assign ram_rstb = 1'b0;

    // RAM output is only meaningful in the cycle after a grant; afterwards the copy is shown.
    assign readData1 = zero1_q ? 32'd0 : ram_doa;
    assign readData2 = zero2_q ? 32'd0 : ram_dob;
    assign rd_valid  = valid_q;
    assign rd_data1  = valid_q ? readData1 : data1_q;
    assign rd_data2  = valid_q ? readData2 : data2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            zero1_q <= 1'b0;
            zero2_q <= 1'b0;
            data1_q <= 32'd0;
            data2_q <= 32'd0;
        end else begin
            valid_q <= rd_gnt;
            if (rd_gnt) begin
                zero1_q <= (rd_addr1 == 5'd0);
                zero2_q <= (rd_addr2 == 5'd0);
            end
            if (valid_q) begin
                data1_q <= readData1;
                data2_q <= readData2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Testbench for regfile_ctrl: behavioral dual-port RAM, table-driven vectors and
// a read scoreboard fed at grant time and drained on rd_valid.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic        rd_req;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        rd_gnt, rd_valid;
    logic [31:0] rd_data1, rd_data2;
    logic [4:0]  ram_addra, ram_addrb;
    logic        ram_cea, ram_ceb, ram_wea, ram_web;
    logic [31:0] ram_dia, ram_dib, ram_doa, ram_dob;
    logic        ram_rsta, ram_rstb;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_wea(ram_wea), .ram_web(ram_web),
        .ram_dia(ram_dia), .ram_dib(ram_dib), .ram_doa(ram_doa), .ram_dob(ram_dob),
        .ram_rsta(ram_rsta), .ram_rstb(ram_rstb)
    );

    // Dual-port RAM, NORMAL write mode; seeded with garbage so the clear sweep is visible.
    logic [31:0] ramMem [32];
    logic        seedRam;
    always @(posedge clk) begin
        if (seedRam) begin
            for (int i = 0; i < 32; i++) ramMem[i] <= $urandom;
        end else begin
            if (ram_cea) begin
                if (ram_wea) ramMem[ram_addra] <= ram_dia;
                ram_doa <= ram_wea ? ram_dia : ramMem[ram_addra];
            end
            if (ram_ceb) begin
                if (ram_web) ramMem[ram_addrb] <= ram_dib;
                ram_dob <= ram_web ? ram_dib : ramMem[ram_addrb];
            end
        end
    end

    // Rising edges since reset release; 16 of them cover the clear sweep.
    int edgeCnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) edgeCnt <= 0;
        else if (edgeCnt < 16) edgeCnt <= edgeCnt + 1;
    end

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        expGnt;
    } vec_t;

    exp_t        sbQ[$];
    logic [31:0] refMem [32];
    logic [31:0] held1, held2;
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check everything just after, update the model.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic rr, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic expGnt);
        logic running;
        logic [4:0] k;
        exp_t item;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = rr; rd_addr1 = a1; rd_addr2 = a2;
        #1;
        running = resetn && (edgeCnt >= 16);
        checkOutput("rd_valid", 32'(rd_valid), 32'(sbQ.size() != 0));
        if (sbQ.size() != 0) begin
            item  = sbQ.pop_front();
            held1 = item.d1;
            held2 = item.d2;
            checkOutput("rd_data1", rd_data1, item.d1);
            checkOutput("rd_data2", rd_data2, item.d2);
        end else begin
            checkOutput("rd_data1_hold", rd_data1, held1);
            checkOutput("rd_data2_hold", rd_data2, held2);
        end
        checkOutput("rd_gnt", 32'(rd_gnt), 32'(expGnt));
        checkOutput("wr_rdy", 32'(wr_rdy), 32'(running));
        checkOutput("ram_rst", 32'({ram_rsta, ram_rstb}), 32'd0);
        if (!running) begin
            k = 5'(edgeCnt);
            checkOutput("clr_ctl", 32'({ram_cea, ram_ceb, ram_wea, ram_web}), 32'hF);
            checkOutput("clr_addra", 32'(ram_addra), 32'({k[3:0], 1'b0}));
            checkOutput("clr_addrb", 32'(ram_addrb), 32'({k[3:0], 1'b1}));
            checkOutput("clr_data", ram_dia | ram_dib, 32'd0);
        end else if (we && wa != 5'd0) begin
            checkOutput("wr_ctl", 32'({ram_cea, ram_ceb, ram_wea, ram_web}), 32'hA);
            checkOutput("wr_addra", 32'(ram_addra), 32'(wa));
            checkOutput("wr_dia", ram_dia, wd);
            refMem[wa] = wd;
        end else if (rr) begin
            checkOutput("rd_ctl", 32'({ram_cea, ram_ceb, ram_wea, ram_web}), 32'hC);
            checkOutput("rd_addr", 32'({ram_addra, ram_addrb}), 32'({a1, a2}));
        end else begin
            checkOutput("idle_ctl", 32'({ram_cea, ram_ceb, ram_wea, ram_web}), 32'h0);
        end
        if (expGnt) begin
            item.d1 = refMem[a1];
            item.d2 = refMem[a2];
            sbQ.push_back(item);
        end
    endtask

    // Reset lands between a falling edge and the next rising edge, cancelling any pending read.
    task automatic doReset();
        resetn = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_data", rd_data1 | rd_data2, 32'd0);
        checkOutput("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        sbQ.delete();
        held1 = 32'd0;
        held2 = 32'd0;
        for (int i = 0; i < 32; i++) refMem[i] = 32'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    vec_t vecs [16];

    initial begin
        resetn = 1'b0; seedRam = 1'b1;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        rd_req = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        held1 = 32'd0; held2 = 32'd0;
        for (int i = 0; i < 32; i++) refMem[i] = 32'd0;

        idle();
        seedRam = 1'b0;
        idle();
        resetn = 1'b1;

        // Requests during the clear sweep are ignored.
        for (int i = 1; i < 16; i++) applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 1'b0);

        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i + 16), 1'b1);
        idle();

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd5,  5'd0,  1'b1};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd3,  1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  5'd5,  1'b1};
        vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd1,  5'd2,  1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd1,  5'd2,  1'b1};
        vecs[6]  = '{1'b1, 5'd1,  32'h11111111, 1'b0, 5'd0,  5'd0,  1'b0};
        vecs[7]  = '{1'b1, 5'd2,  32'h22222222, 1'b0, 5'd0,  5'd0,  1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd0,  1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd1,  5'd2,  1'b1};
        vecs[10] = '{1'b1, 5'd1,  32'h33333333, 1'b0, 5'd0,  5'd0,  1'b0};
        vecs[11] = '{1'b1, 5'd0,  32'h55555555, 1'b1, 5'd7,  5'd1,  1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd0,  1'b0};
        vecs[13] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd31, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd31, 5'd5,  1'b1};
        vecs[15] = '{1'b1, 5'd2,  32'h0BADF00D, 1'b0, 5'd0,  5'd0,  1'b0};
        foreach (vecs[i])
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rr,
                          vecs[i].a1, vecs[i].a2, vecs[i].expGnt);

        // Eight back-to-back grants.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i), 1'b1);
        idle();
        idle();

        // Reset during a granted read, then x5 must read back as zero.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7, 1'b1);
        doReset();
        for (int i = 1; i < 16; i++) idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7, 1'b1);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameters: none; fixed 32 x 32-bit register file, 5-bit addresses.
REQ-002 clk  in  1  sole clock, rising edge; also drives the attached dual-port RAM clocks.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 wr_en  in  1  write request, register x[wr_addr] <= wr_data.
REQ-005 wr_addr  in  5  write register index.
REQ-006 wr_data  in  32  write data.
REQ-007 wr_rdy  out  1  high when writes are accepted (= not clearing).
REQ-008 rd_req  in  1  read request for rs1/rs2 pair.
REQ-009 rd_addr1, rd_addr2  in  5 each  read indices.
REQ-010 rd_gnt  out  1  combinational: read request accepted this cycle.
REQ-011 rd_valid  out  1  one-cycle pulse, read data available.
REQ-012 rd_data1, rd_data2  out  32 each  read results.
REQ-013 ram_addra, ram_addrb  out  5 each; ram_cea, ram_ceb, ram_wea, ram_web  out  1 each; ram_dia, ram_dib  out  32 each; ram_doa, ram_dob  in  32 each: connection to 32x32 dual-port RAM, synchronous read, 1-cycle latency, unregistered output, NORMAL write mode (doa shows written data on a port-A write).
REQ-014 ram_rsta, ram_rstb  out  1 each  tied low.

Function
REQ-015 States CLEAR and RUN; resetn low forces CLEAR with clear counter = 0.
REQ-016 CLEAR: for counter k = 0..15, port A writes 0 to address 2k, port B writes 0 to 2k+1 (cea=ceb=wea=web=1, dia=dib=0); counter increments each cycle; after k=15 transition to RUN; CLEAR lasts exactly 16 cycles.
REQ-017 In CLEAR: wr_rdy=0, rd_gnt=0, wr_en and rd_req ignored (requester holds until serviced).
REQ-018 RUN, wr_en=1 and wr_addr!=0: port A writes (ram_addra=wr_addr, cea=wea=1, dia=wr_data); any rd_req in that cycle is not granted.
REQ-019 RUN, wr_en=1 and wr_addr=0: write dropped, no RAM access, does not block reads.
REQ-020 rd_gnt = rd_req AND RUN AND NOT (wr_en AND wr_addr!=0).
REQ-021 On grant: ram_addra=rd_addr1, ram_addrb=rd_addr2, cea=ceb=1, wea=web=0; rd_valid=1 in the next cycle.
REQ-022 In rd_valid cycle: rd_data1=ram_doa, rd_data2=ram_dob, except forced 0 where the granted address was 0 (flags registered at grant).
REQ-023 rd_data1/rd_data2 held stable (registered copy) from rd_valid cycle until the next rd_valid, regardless of intervening port-A writes.
REQ-024 Back-to-back grants allowed: rd_valid may be high on consecutive cycles.
REQ-025 Write then read of same index on next cycle returns new value (write completes at edge before read edge); no bypass path required.
REQ-026 Idle cycles: cea=ceb=wea=web=0.

Reset
REQ-027 Reset values: state=CLEAR, counter=0, rd_valid=0, rd_data1=rd_data2=0, wr_rdy=0.
REQ-028 Reset asserted mid-CLEAR or mid-read: restart CLEAR from address 0 on release; pending rd_valid cancelled.
REQ-029 First RUN cycle is the 17th rising edge after resetn deasserts.

Verification
REQ-030 Release reset -> 16 cycles of paired zero writes to addrs (0,1)..(30,31), wr_rdy rises at cycle 17; read all 32 -> all 0.
REQ-031 Write x5=0xDEADBEEF, next cycle read (5,0) -> rd_gnt=1, next cycle rd_valid=1, rd_data1=0xDEADBEEF, rd_data2=0.
REQ-032 Write x0=0x12345678 with rd_req(0,3) same cycle -> rd_gnt=1, rd_data1=0; later read x0 -> 0.
REQ-033 wr_en(x7=0xA5A5A5A5) with rd_req(1,2) same cycle -> rd_gnt=0; next cycle grant; rd_data held constant across further writes until next rd_valid.
REQ-034 Assert resetn low during a granted read -> rd_valid stays 0; CLEAR restarts; previously written x5 reads 0 afterward.
REQ-035 Continuous rd_req for 8 cycles, no writes -> 8 consecutive rd_valid pulses with correct data.
